// File: rtl/usb_cdc_tx_arbiter_if.sv
// Requester-side byte streams and tx FIFO write port shared by the USB CDC tx arbiter.
interface usb_cdc_tx_arbiter_if #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned DW   = 8
);
    logic [NREQ-1:0]    req_en;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_last;
    logic [NREQ-1:0]    req_ready;
    logic               fifo_wr;
    logic [DW-1:0]      fifo_wdata;
    logic               fifo_full;

    // Environment side: requesters plus the FIFO full flag
    modport master (
        output req_en, req_valid, req_data, req_last, fifo_full,
        input  req_ready, fifo_wr, fifo_wdata
    );

    // Arbiter side
    modport slave (
        input  req_en, req_valid, req_data, req_last, fifo_full,
        output req_ready, fifo_wr, fifo_wdata
    );
endinterface

// File: rtl/usb_cdc_tx_arbiter.sv
// Round-robin arbiter sharing the USB CDC tx FIFO write port between NREQ byte streams;
// a grant lasts for one burst (last flag, length limit, pause or disable).
module usb_cdc_tx_arbiter #(
    parameter int unsigned NREQ      = 2,
    parameter int unsigned DW        = 8,
    parameter int unsigned MAX_BURST = 8,
    parameter int unsigned BCW       = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    usb_cdc_tx_arbiter_if.slave bus,
    output logic [NREQ-1:0]     grant_o,
    output logic                busy_o,
    output logic [BCW-1:0]      burst_cnt_o
);

    localparam int unsigned    IW       = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [BCW-1:0] LAST_CNT = BCW'(MAX_BURST - 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t          state_q, state_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [BCW-1:0]  cnt_q, cnt_d;
    logic            busy_q;

    logic [NREQ-1:0] elig;
    logic [IW-1:0]   pick;
    logic            sel_valid, sel_last, sel_en;
    logic [DW-1:0]   sel_data;
    logic            xfer;

    // ptr_q doubles as the granted index while in GRANT
    always_comb begin : sel_mux
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_en    = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (ptr_q == IW'(i)) begin
                sel_valid = bus.req_valid[i];
                sel_last  = bus.req_last[i];
                sel_en    = bus.req_en[i];
                sel_data  = bus.req_data[i*DW +: DW];
            end
        end
    end

    // First eligible index after ptr_q, wrapping; the k=1 candidate is applied last and wins
    always_comb begin : rr_pick
        elig = bus.req_en & bus.req_valid;
        pick = ptr_q;
        for (int k = int'(NREQ); k >= 1; k--) begin
            for (int i = 0; i < int'(NREQ); i++) begin
                if (elig[i] && (i == (int'(ptr_q) + k) % int'(NREQ))) begin
                    pick = IW'(i);
                end
            end
        end
    end

    always_comb begin : fsm_next
        state_d        = state_q;
        grant_d        = grant_q;
        ptr_d          = ptr_q;
        cnt_d          = cnt_q;
        xfer           = 1'b0;
        bus.req_ready  = '0;
        bus.fifo_wr    = 1'b0;
        bus.fifo_wdata = '0;
        case (state_q)
            IDLE: begin
                if (|elig) begin
                    state_d = GRANT;
                    grant_d = NREQ'(1) << pick;
                    ptr_d   = pick;
                    cnt_d   = '0;
                end
            end
            GRANT: begin
                xfer           = sel_valid & ~bus.fifo_full;
                bus.req_ready  = grant_q & {NREQ{~bus.fifo_full}};
                bus.fifo_wr    = xfer;
                bus.fifo_wdata = sel_data;
                if (xfer) begin
                    cnt_d = cnt_q + BCW'(1);
                end
                // Backpressure alone never releases: a stalled valid keeps the grant
                if ((xfer & (sel_last | (cnt_q == LAST_CNT))) | ~sel_valid | ~sel_en) begin
                    state_d = IDLE;
                    grant_d = '0;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin : fsm_reg
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= IW'(NREQ - 1);
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            busy_q  <= (state_d == GRANT);
        end
    end

    assign grant_o     = grant_q;
    assign busy_o      = busy_q;
    assign burst_cnt_o = cnt_q;

endmodule

// File: tb/tb_usb_cdc_tx_arbiter.sv
// Directed bench for usb_cdc_tx_arbiter: per-cycle reference model plus literal checks
// of grant timing, written byte streams, stalls, pauses, enables and mid-burst reset.
module tb_usb_cdc_tx_arbiter;
    localparam int NREQ = 2, DW = 8, MAX_BURST = 8, BCW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    usb_cdc_tx_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus();
    logic [NREQ-1:0] grant_o;
    logic            busy_o;
    logic [BCW-1:0]  burst_cnt_o;

    usb_cdc_tx_arbiter #(.NREQ(NREQ), .DW(DW), .MAX_BURST(MAX_BURST), .BCW(BCW)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .grant_o(grant_o), .busy_o(busy_o), .burst_cnt_o(burst_cnt_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Requester sources: rem bytes left (-1 = endless), nxt current byte
    int              rem  [NREQ];
    logic [7:0]      nxt  [NREQ];
    logic [7:0]      step [NREQ];
    bit              lastend [NREQ];
    logic [NREQ-1:0] en;
    logic [NREQ-1:0] hs = '0;
    logic [7:0]      cap[$];

    int m_g, m_ptr, m_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic chk_cap(input string name, input int idx, input logic [7:0] exp);
        logic [31:0] act;
        act = (idx < cap.size()) ? 32'(cap[idx]) : 32'hDEAD;
        chk(name, act, 32'(exp));
    endtask

    task automatic apply();
        for (int i = 0; i < NREQ; i++) begin
            bus.req_valid[i]         = (rem[i] != 0);
            bus.req_data[i*DW +: DW] = nxt[i];
            bus.req_last[i]          = lastend[i] && (rem[i] == 1);
        end
        bus.req_en = en;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (hs[i]) begin
                if (rem[i] > 0) rem[i]--;
                nxt[i] = nxt[i] + step[i];
            end
        end
        apply();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.fifo_full = 1'b0;
        en = '1;
        for (int i = 0; i < NREQ; i++) begin
            rem[i] = 0; nxt[i] = 8'h00; step[i] = 8'h01; lastend[i] = 1'b0;
        end
        apply();
        tick();
        tick();
        rst_n = 1'b1;
        cap.delete();
    endtask

    // Reference model: grant index or -1, round-robin pointer, bytes moved in this grant
    always @(negedge clk) begin : cmp
        logic [NREQ-1:0] eg, er;
        logic [7:0]      ed;
        bit              vg, xf, found;
        int              c;
        if (!rst_n) begin
            m_g = -1; m_ptr = NREQ - 1; m_cnt = 0;
            chk("rst_grant", 32'(grant_o), 0);
            chk("rst_busy", 32'(busy_o), 0);
            chk("rst_cnt", 32'(burst_cnt_o), 0);
            chk("rst_ready", 32'(bus.req_ready), 0);
            chk("rst_wr", 32'(bus.fifo_wr), 0);
            chk("rst_wdata", 32'(bus.fifo_wdata), 0);
        end else begin
            eg = '0; er = '0; ed = '0; vg = 0;
            if (m_g >= 0) begin
                eg[m_g] = 1'b1;
                er[m_g] = ~bus.fifo_full;
                ed = bus.req_data[m_g*DW +: DW];
                vg = bus.req_valid[m_g];
            end
            xf = vg && !bus.fifo_full;
            chk("grant", 32'(grant_o), 32'(eg));
            chk("busy", 32'(busy_o), 32'(m_g >= 0));
            chk("cnt", 32'(burst_cnt_o), 32'(m_cnt));
            chk("ready", 32'(bus.req_ready), 32'(er));
            chk("wr", 32'(bus.fifo_wr), 32'(xf));
            chk("wdata", 32'(bus.fifo_wdata), 32'(ed));
            if (bus.fifo_wr) cap.push_back(bus.fifo_wdata);
            if (m_g < 0) begin
                found = 0;
                for (int k = 1; k <= NREQ; k++) begin
                    c = (m_ptr + k) % NREQ;
                    if (!found && bus.req_en[c] && bus.req_valid[c]) begin
                        found = 1; m_g = c; m_ptr = c; m_cnt = 0;
                    end
                end
            end else begin
                if (xf) m_cnt++;
                if ((xf && bus.req_last[m_g]) || m_cnt == MAX_BURST || !vg || !bus.req_en[m_g]) begin
                    m_g = -1; m_cnt = 0;
                end
            end
        end
        hs = bus.req_valid & bus.req_ready;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [7:0] gh [32];
        logic [3:0] ch [32];

        // Single 3-byte burst from requester 0
        do_reset();
        rem[0] = 3; nxt[0] = 8'h11; step[0] = 8'h11; lastend[0] = 1'b1;
        apply();
        tick();
        chk("t1_grant", 32'(grant_o), 32'h1);
        chk("t1_busy", 32'(busy_o), 1);
        tick(); tick(); tick();
        chk("t1_busy_end", 32'(busy_o), 0);
        chk("t1_size", 32'(cap.size()), 3);
        chk_cap("t1_b0", 0, 8'h11);
        chk_cap("t1_b1", 1, 8'h22);
        chk_cap("t1_b2", 2, 8'h33);

        // Continuous demand from both: 8-byte bursts alternating with one idle cycle
        do_reset();
        rem[0] = -1; rem[1] = -1; nxt[0] = 8'h00; nxt[1] = 8'h80;
        apply();
        for (int t = 1; t <= 27; t++) begin
            tick();
            gh[t] = 8'(grant_o);
            ch[t] = burst_cnt_o;
        end
        chk("t2_g1", 32'(gh[1]), 32'h1);
        chk("t2_cnt8", 32'(ch[8]), 7);
        chk("t2_g9", 32'(gh[9]), 0);
        chk("t2_g10", 32'(gh[10]), 32'h2);
        chk("t2_g18", 32'(gh[18]), 0);
        chk("t2_g19", 32'(gh[19]), 32'h1);
        chk("t2_size", 32'(cap.size()), 24);
        for (int j = 0; j < 24; j++) begin
            if (j < 8)       chk_cap("t2_byte", j, 8'(j));
            else if (j < 16) chk_cap("t2_byte", j, 8'(8'h80 + j - 8));
            else             chk_cap("t2_byte", j, 8'(j - 8));
        end

        // FIFO full for 5 cycles after byte 2
        do_reset();
        rem[0] = 6; nxt[0] = 8'h40; lastend[0] = 1'b1;
        apply();
        tick(); tick(); tick();
        bus.fifo_full = 1'b1;
        tick(); tick();
        chk("t3_stall_grant", 32'(grant_o), 32'h1);
        chk("t3_stall_wr", 32'(bus.fifo_wr), 0);
        chk("t3_stall_ready", 32'(bus.req_ready), 0);
        chk("t3_stall_size", 32'(cap.size()), 2);
        tick(); tick(); tick();
        bus.fifo_full = 1'b0;
        tick(); tick(); tick(); tick();
        chk("t3_busy_end", 32'(busy_o), 0);
        chk("t3_size", 32'(cap.size()), 6);
        for (int j = 0; j < 6; j++) chk_cap("t3_byte", j, 8'(8'h40 + j));

        // Requester 1 pauses after 2 bytes; waiting requester 0 goes next
        do_reset();
        rem[1] = 2; nxt[1] = 8'hA0;
        apply();
        tick();
        chk("t4_g1", 32'(grant_o), 32'h2);
        rem[0] = 3; nxt[0] = 8'h10; lastend[0] = 1'b1;
        apply();
        tick(); tick();
        tick();
        chk("t4_idle", 32'(grant_o), 0);
        rem[1] = 2;
        apply();
        tick();
        chk("t4_g5", 32'(grant_o), 32'h1);
        tick(); tick(); tick(); tick();
        chk("t4_g9", 32'(grant_o), 32'h2);
        tick(); tick(); tick();
        chk("t4_busy_end", 32'(busy_o), 0);
        chk("t4_size", 32'(cap.size()), 7);
        chk_cap("t4_b0", 0, 8'hA0);
        chk_cap("t4_b1", 1, 8'hA1);
        chk_cap("t4_b2", 2, 8'h10);
        chk_cap("t4_b3", 3, 8'h11);
        chk_cap("t4_b4", 4, 8'h12);
        chk_cap("t4_b5", 5, 8'hA2);
        chk_cap("t4_b6", 6, 8'hA3);

        // Requester 0 disabled; dropping enable of 1 releases after the current byte
        do_reset();
        en = 2'b10; rem[0] = -1; rem[1] = -1; nxt[1] = 8'hC0;
        apply();
        tick();
        chk("t5_g1", 32'(grant_o), 32'h2);
        tick(); tick();
        en[1] = 1'b0;
        apply();
        tick();
        chk("t5_released", 32'(grant_o), 0);
        tick(); tick(); tick();
        chk("t5_still_idle", 32'(busy_o), 0);
        chk("t5_size", 32'(cap.size()), 3);
        for (int j = 0; j < 3; j++) chk_cap("t5_byte", j, 8'(8'hC0 + j));

        // Reset in the middle of a burst after 4 bytes
        do_reset();
        rem[0] = -1; rem[1] = -1; nxt[0] = 8'h50; nxt[1] = 8'h90;
        apply();
        tick();
        chk("t6_g1", 32'(grant_o), 32'h1);
        tick(); tick(); tick(); tick();
        chk("t6_cnt_pre", 32'(burst_cnt_o), 4);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_grant", 32'(grant_o), 0);
        chk("t6_rst_busy", 32'(busy_o), 0);
        chk("t6_rst_cnt", 32'(burst_cnt_o), 0);
        chk("t6_rst_wr", 32'(bus.fifo_wr), 0);
        chk("t6_rst_ready", 32'(bus.req_ready), 0);
        chk("t6_rst_size", 32'(cap.size()), 4);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        chk("t6_regrant", 32'(grant_o), 32'h1);
        chk("t6_cnt0", 32'(burst_cnt_o), 0);
        tick();
        chk("t6_cnt1", 32'(burst_cnt_o), 1);
        chk("t6_size", 32'(cap.size()), 5);
        for (int j = 0; j < 5; j++) chk_cap("t6_byte", j, 8'(8'h50 + j));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/usb_cdc_tx_arbiter.md
Name: usb_cdc_tx_arbiter

Overview:
Round-robin arbiter that shares the USB CDC transmit FIFO write port between NREQ byte-stream requesters, e.g. the CPU bus interface and a DMA channel. A requester holds the grant for a burst that ends on its last flag, on a burst-length limit or when it stops presenting data. Bytes from one burst are never interleaved with bytes from another. The block sits between the requesters and the tx FIFO (tx_fifo_wr, tx_fifo_wdata, tx_fifo_full) of the USB CDC wrapper, in the same clock domain.

Parameters:
NREQ, 2, number of requesters (2..8)
DW, 8, data width per requester
MAX_BURST, 8, maximum bytes per grant; default matches the 8-byte IN bulk packet size
BCW, 4, burst counter width; must satisfy 2**BCW > MAX_BURST

Ports:
clk  input  1  system clock (same clock as the tx FIFO)
rst_n  input  1  reset, asynchronous, active-low
req_en  input  NREQ  per-requester enable; a disabled requester is never granted
req_valid  input  NREQ  requester i presents a byte
req_data  input  NREQ*DW  requester i byte at bits [i*DW +: DW]
req_last  input  NREQ  qualifies req_valid[i]: the current byte ends the burst
req_ready  output  NREQ  byte accepted this cycle when req_valid[i] & req_ready[i]
fifo_wr  output  1  write strobe to the tx FIFO
fifo_wdata  output  DW  write data to the tx FIFO
fifo_full  input  1  tx FIFO full flag
grant_o  output  NREQ  one-hot current grant, registered
busy_o  output  1  high while in GRANT
burst_cnt_o  output  BCW  bytes transferred in the current grant

Behaviour:
- Reset (async, rst_n=0): state=IDLE, grant_o=0, busy_o=0, burst_cnt_o=0, rr_ptr=NREQ-1 so requester 0 wins first. Combinational outputs follow: req_ready=0, fifo_wr=0, fifo_wdata=0. Reset mid-burst aborts it with no further writes; the bytes already written stay in the FIFO.
- Eligible requester i: req_en[i] & req_valid[i].
- State IDLE:
  - If no requester is eligible: stay in IDLE.
  - Otherwise: search from rr_ptr+1 upward, modulo NREQ, and pick the first eligible index g. On the next edge: grant_o=onehot(g), rr_ptr=g, burst_cnt=0, state=GRANT.
  - No transfer takes place in IDLE.
  - Arbitration latency is 1 cycle from valid to grant. The first byte can transfer in the cycle after that.
- State GRANT (granted index g):
  - req_ready[g] = ~fifo_full. All other req_ready bits = 0.
  - xfer = req_valid[g] & ~fifo_full. fifo_wr = xfer, fifo_wdata = req_data[g]. fifo_wdata = 0 when not in GRANT.
  - On xfer: burst_cnt increments by 1.
  - Release condition, evaluated each cycle:
    - (a) xfer & req_last[g]
    - (b) xfer & burst_cnt+1 == MAX_BURST
    - (c) ~req_valid[g], i.e. the requester paused
    - (d) ~req_en[g]
  - On release: the next edge gives grant_o=0, burst_cnt=0, state=IDLE.
  - There is exactly one IDLE cycle between consecutive grants.
- fifo_full with req_valid[g] high: stall, hold the grant, no write, burst_cnt unchanged. Backpressure never causes a release.
- req_last[i] is ignored unless req_valid[i] & req_ready[i].
- burst_cnt saturates logically at MAX_BURST because condition (b) forces release. The counter is never compared beyond MAX_BURST.
- Requesters must hold req_data and req_last stable while req_valid is high and req_ready is low. The arbiter does not check this.
- Fairness: under continuous demand from all requesters, each one is granted once every NREQ grants.

Test Plan:
- Reset, then req_valid=2'b01 with 3 bytes 0x11,0x22,0x33 and last on 0x33 -> grant_o=01 one cycle after valid; fifo_wr high for 3 consecutive cycles carrying 0x11,0x22,0x33; then IDLE and busy_o=0.
- Both requesters valid continuously, no last, MAX_BURST=8 -> grants alternate 01,10,01,...; each grant writes exactly 8 bytes; one idle cycle between grants; burst_cnt_o reaches 7 on the final byte.
- Requester 0 granted, fifo_full asserted for 5 cycles after byte 2 -> no fifo_wr and req_ready[0]=0 during the stall; grant held; burst resumes at byte 3; no bytes lost or duplicated.
- Requester 1 drops req_valid after 2 bytes, no last -> release; requester 0, which was waiting, is granted 2 cycles later; requester 1 is re-granted only after requester 0's burst.
- req_en=2'b10 with both requesters valid -> requester 0 is never granted; clearing req_en[1] mid-burst releases it after the current cycle.
- rst_n asserted mid-burst after 4 bytes -> outputs go to 0 immediately; after rst_n is deasserted, requester 0 wins first and burst_cnt_o restarts at 0.
